// File: rtl/timer_counter.sv
// timer_counter: memory-mapped down-counting timer with interrupt.
//
// Ports:
//   clk    - system clock, all state updates on rising edge
//   reset  - synchronous active-high reset
//   Addr   - byte address from bridge; only Addr[3:2] selects a register
//   WE     - write enable for the selected register
//   Din    - write data
//   Dout   - combinational read data of the selected register
//   IRQ    - interrupt request (CTRL.IM & irq_flag)
//
// Register map (Addr[3:2]):
//   00 CTRL   : [0] EN, [2:1] MODE, [3] IM. Writing acknowledges the IRQ.
//   01 PRESET : reload value, sampled by the FSM in LOAD.
//   10 COUNT  : read-only current count.
//   11        : reserved, reads 0.
module timer_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      Addr,
   input  logic             WE,
   input  logic [WIDTH-1:0] Din,
   output logic [WIDTH-1:0] Dout,
   output logic             IRQ
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CNT  = 2'd2,
      ST_INT  = 2'd3
   } state_e;

   localparam logic [1:0] A_CTRL   = 2'b00;
   localparam logic [1:0] A_PRESET = 2'b01;
   localparam logic [1:0] A_COUNT  = 2'b10;

   // Mode 01 is the only auto-reload mode; every other encoding is one-shot.
   localparam logic [1:0] MODE_RELOAD = 2'b01;

   logic [3:0]       ctrl_q,     ctrl_d;
   logic [WIDTH-1:0] preset_q,   preset_d;
   logic [WIDTH-1:0] count_q,    count_d;
   state_e           state_q,    state_d;
   logic             irq_flag_q, irq_flag_d;

   logic       ctrl_en;
   logic [1:0] ctrl_mode;
   logic       ctrl_im;
   logic [1:0] reg_sel;

   assign ctrl_en   = ctrl_q[0];
   assign ctrl_mode = ctrl_q[2:1];
   assign ctrl_im   = ctrl_q[3];
   assign reg_sel   = Addr[3:2];

   // The bridge has already range-checked the address; the remaining bits
   // carry no information for this block.
   logic unused_addr;
   assign unused_addr = ^{Addr[31:4], Addr[1:0]};

   // Next-state: FSM first, then the bus write so a same-cycle CTRL write
   // overrides the FSM's effect on both CTRL and irq_flag.
   always_comb begin
      ctrl_d     = ctrl_q;
      preset_d   = preset_q;
      count_d    = count_q;
      state_d    = state_q;
      irq_flag_d = irq_flag_q;

      unique case (state_q)
         ST_IDLE: begin
            if (ctrl_en) begin
               state_d    = ST_LOAD;
               irq_flag_d = 1'b0;
            end
         end
         ST_LOAD: begin
            count_d = preset_q;
            state_d = ST_CNT;
         end
         ST_CNT: begin
            if (!ctrl_en) begin
               state_d = ST_IDLE;
            end else if (count_q > WIDTH'(1)) begin
               count_d = count_q - WIDTH'(1);
            end else begin
               // Covers PRESET of 0 or 1 as well; never wraps below zero.
               count_d = '0;
               state_d = ST_INT;
            end
         end
         ST_INT: begin
            irq_flag_d = 1'b1;
            state_d    = ST_IDLE;
            if (ctrl_mode != MODE_RELOAD) ctrl_d[0] = 1'b0;
         end
         default: state_d = ST_IDLE;
      endcase

      if (WE) begin
         unique case (reg_sel)
            A_CTRL: begin
               ctrl_d     = Din[3:0];
               irq_flag_d = 1'b0;
            end
            A_PRESET: preset_d = Din;
            default: ;  // COUNT is read-only, offset 3 is reserved
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl_q     <= '0;
         preset_q   <= '0;
         count_q    <= '0;
         state_q    <= ST_IDLE;
         irq_flag_q <= 1'b0;
      end else begin
         ctrl_q     <= ctrl_d;
         preset_q   <= preset_d;
         count_q    <= count_d;
         state_q    <= state_d;
         irq_flag_q <= irq_flag_d;
      end
   end

   always_comb begin
      Dout = '0;
      unique case (reg_sel)
         A_CTRL:   Dout = {{(WIDTH-4){1'b0}}, ctrl_q};
         A_PRESET: Dout = preset_q;
         A_COUNT:  Dout = count_q;
         default:  Dout = '0;
      endcase
   end

   assign IRQ = ctrl_im & irq_flag_q;

endmodule

// File: tb/tb_timer_counter.sv
// Scoreboard bench for timer_counter: stimulus pushes expected read data and
// IRQ level, a negedge monitor pops and compares.
module tb_timer_counter;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] Addr;
   logic        WE;
   logic [31:0] Din;
   logic [31:0] Dout;
   logic        IRQ;

   timer_counter #(.WIDTH(32)) dut (
      .clk  (clk),
      .reset(reset),
      .Addr (Addr),
      .WE   (WE),
      .Din  (Din),
      .Dout (Dout),
      .IRQ  (IRQ)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] dout;
      int          irq;   // -1: IRQ not checked
   } exp_t;

   exp_t        sb_q[$];
   int          total = 0;
   int          bad   = 0;
   logic [31:0] base  = 32'h0000_7F00;

   localparam logic [1:0] R_CTRL = 2'd0, R_PRE = 2'd1, R_CNT = 2'd2, R_RSV = 2'd3;

   // Monitor: the DUT presents a value every cycle; sample mid-cycle when
   // the stimulus has queued an expectation.
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         total++;
         if (Dout !== e.dout) begin
            bad++;
            $display("FAIL %s dout: got %h want %h", e.name, Dout, e.dout);
         end
         if (e.irq >= 0) begin
            total++;
            if (IRQ !== e.irq[0]) begin
               bad++;
               $display("FAIL %s irq: got %b want %0d", e.name, IRQ, e.irq);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      Addr = base | {28'h0, a, 2'b00};
      Din  = d;
      WE   = 1'b1;
      step();
      WE   = 1'b0;
   endtask

   // Samples at the next falling edge, i.e. in the current cycle if called
   // right after step()/wr(), otherwise one edge later.
   task automatic chk(input string n, input logic [1:0] a,
                      input logic [31:0] d, input int irq);
      exp_t e;
      Addr = base | {28'h0, a, 2'b00};
      WE   = 1'b0;
      e.name = n; e.dout = d; e.irq = irq;
      sb_q.push_back(e);
      @(negedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; WE = 1'b0; Addr = '0; Din = '0;
      step(); step();
      reset = 1'b0;

      // Reset state and read-only / reserved write protection.
      chk("rst_ctrl", R_CTRL, 32'h0, 0);
      chk("rst_pre",  R_PRE,  32'h0, 0);
      chk("rst_cnt",  R_CNT,  32'h0, 0);
      chk("rst_rsv",  R_RSV,  32'h0, 0);
      wr(R_CNT, 32'h55);
      wr(R_RSV, 32'hFF);
      chk("cnt_ro",   R_CNT,  32'h0, 0);
      chk("rsv_ro",   R_RSV,  32'h0, 0);

      // One-shot, PRESET=5, CTRL=0x9 at edge E: IRQ from E+8 and held.
      wr(R_PRE, 32'd5);
      wr(R_CTRL, 32'h9);
      step();
      for (int k = 2; k <= 7; k++) begin
         step();
         chk($sformatf("os_cnt_e%0d", k), R_CNT, 32'(7 - k), 0);
      end
      for (int k = 8; k < 28; k++) begin
         step();
         chk($sformatf("os_hold_e%0d", k), R_CNT, 32'h0, 1);
      end
      chk("os_ctrl", R_CTRL, 32'h8, 1);
      wr(R_CTRL, 32'h0);
      chk("os_ack", R_CTRL, 32'h0, 0);

      // Auto-reload on the TC2 window, PRESET=3: 1-cycle pulse every 6.
      base = 32'h0000_7F10;
      wr(R_PRE, 32'd3);
      wr(R_CTRL, 32'hB);
      for (int k = 1; k <= 20; k++) begin
         step();
         chk($sformatf("ar_e%0d", k), R_CTRL, 32'hB,
             (k % 6 == 0) ? 1 : 0);
      end
      wr(R_CTRL, 32'h0);
      step(); step(); step();
      chk("ar_stop", R_CNT, 32'd2, 0);

      // One-shot with IM=0: flag sets silently, CTRL write clears it.
      base = 32'h0000_7F00;
      wr(R_PRE, 32'd2);
      wr(R_CTRL, 32'h1);
      for (int k = 0; k < 6; k++) step();
      chk("noim_done", R_CTRL, 32'h0, 0);
      wr(R_CTRL, 32'h8);
      chk("noim_ack", R_CTRL, 32'h8, 0);
      step(); step(); step();
      chk("noim_quiet", R_CTRL, 32'h8, 0);

      // PRESET rewrite mid-count does not reload; disable freezes COUNT.
      wr(R_PRE, 32'd10);
      wr(R_CTRL, 32'h9);
      step(); step();
      chk("mid_e2", R_CNT, 32'd10, 0);
      step();
      chk("mid_e3", R_CNT, 32'd9, 0);
      wr(R_PRE, 32'd2);
      chk("mid_e4", R_CNT, 32'd8, 0);
      chk("mid_pre", R_PRE, 32'd2, 0);
      wr(R_CTRL, 32'h0);
      chk("mid_dis", R_CNT, 32'd6, 0);
      step(); step(); step();
      chk("mid_frozen", R_CNT, 32'd6, 0);

      // Reset in the middle of a count.
      wr(R_PRE, 32'd10);
      wr(R_CTRL, 32'h9);
      for (int k = 0; k < 5; k++) step();
      chk("pre_rst_cnt", R_CNT, 32'd7, 0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("mrst_ctrl", R_CTRL, 32'h0, 0);
      chk("mrst_pre",  R_PRE,  32'h0, 0);
      chk("mrst_cnt",  R_CNT,  32'h0, 0);
      chk("mrst_rsv",  R_RSV,  32'h0, 0);
      for (int k = 0; k < 15; k++) begin
         step();
         chk("mrst_quiet", R_CNT, 32'h0, 0);
      end

      // PRESET=0: shortest path LOAD -> CNT -> INT -> IDLE.
      wr(R_PRE, 32'd0);
      wr(R_CTRL, 32'h9);
      step(); step();
      chk("p0_e2", R_CNT, 32'h0, 0);
      chk("p0_e3", R_CNT, 32'h0, -1);
      chk("p0_e4", R_CNT, 32'h0, 1);
      chk("p0_ctrl", R_CTRL, 32'h8, 1);

      @(negedge clk);
      #1;
      if (sb_q.size() != 0) begin
         bad++;
         $display("FAIL drain: pending=%0d want 0", sb_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
